// File: rtl/axis_gmii_tx.sv
// AXI-Stream to 8-bit GMII transmitter: adds preamble/SFD, zero padding, CRC-32 FCS and IFG.
// Source starvation mid-payload terminates the frame with tx_er and discards the rest of it.
module axis_gmii_tx #(
    parameter int DATA_W         = 8,
    parameter bit ENABLE_PADDING = 1'b1,
    parameter int MIN_FRAME_LEN  = 64,
    parameter int IFG_CYCLES     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [DATA_W-1:0] gmii_txd,
    output logic              gmii_tx_en,
    output logic              gmii_tx_er,
    output logic              start_packet,
    output logic              er_underflow
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DROP
    } state_t;

    localparam logic [15:0] PAD_LEN  = 16'(MIN_FRAME_LEN - 4);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    state_t            state_q;
    logic [31:0]       crc_q;
    logic [31:0]       crc_d;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic [15:0]       step_q;
    logic [7:0]        crc_in;
    logic [DATA_W-1:0] txd_q;
    logic              tx_en_q;
    logic              tx_er_q;
    logic              tready_q;
    logic              start_q;
    logic              uf_q;

    // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        crc_in = (state_q == ST_PAD) ? 8'h00 : s_axis_tdata[7:0];
        crc_d  = crc32_byte(crc_q, crc_in);
        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            crc_q    <= '1;
            cnt_q    <= '0;
            step_q   <= '0;
            txd_q    <= '0;
            tx_en_q  <= 1'b0;
            tx_er_q  <= 1'b0;
            tready_q <= 1'b0;
            start_q  <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            uf_q    <= 1'b0;
            tx_er_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    txd_q    <= '0;
                    tx_en_q  <= 1'b0;
                    tready_q <= 1'b0;
                    crc_q    <= '1;
                    cnt_q    <= '0;
                    step_q   <= '0;
                    if (s_axis_tvalid) begin
                        state_q <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    tx_en_q <= 1'b1;
                    start_q <= (step_q == 16'd0);
                    if (step_q == 16'd7) begin
                        // tready rises with the SFD so the first beat lands right behind it
                        txd_q    <= 8'hD5;
                        tready_q <= 1'b1;
                        step_q   <= '0;
                        state_q  <= ST_PAYLOAD;
                    end else begin
                        txd_q  <= 8'h55;
                        step_q <= step_q + 16'd1;
                    end
                end
                ST_PAYLOAD: begin
                    tx_en_q <= 1'b1;
                    if (s_axis_tvalid) begin
                        txd_q   <= s_axis_tdata;
                        tx_er_q <= s_axis_tlast & s_axis_tuser;
                        crc_q   <= crc_d;
                        cnt_q   <= cnt_d;
                        if (s_axis_tlast) begin
                            tready_q <= 1'b0;
                            step_q   <= '0;
                            state_q  <= (ENABLE_PADDING && (cnt_d < PAD_LEN)) ? ST_PAD : ST_FCS;
                        end
                    end else begin
                        txd_q   <= '0;
                        tx_er_q <= 1'b1;
                        uf_q    <= 1'b1;
                        state_q <= ST_DROP;
                    end
                end
                ST_PAD: begin
                    txd_q   <= '0;
                    tx_en_q <= 1'b1;
                    crc_q   <= crc_d;
                    cnt_q   <= cnt_d;
                    if (cnt_d >= PAD_LEN) begin
                        step_q  <= '0;
                        state_q <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    tx_en_q <= 1'b1;
                    txd_q   <= ~crc_q[{step_q[1:0], 3'b000} +: 8];
                    if (step_q == 16'd3) begin
                        step_q  <= '0;
                        state_q <= ST_IFG;
                    end else begin
                        step_q <= step_q + 16'd1;
                    end
                end
                ST_IFG: begin
                    txd_q   <= '0;
                    tx_en_q <= 1'b0;
                    if (step_q == IFG_LAST) begin
                        step_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        step_q <= step_q + 16'd1;
                    end
                end
                ST_DROP: begin
                    txd_q   <= '0;
                    tx_en_q <= 1'b0;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        tready_q <= 1'b0;
                        step_q   <= '0;
                        state_q  <= ST_IFG;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gmii_txd      = txd_q;
    assign gmii_tx_en    = tx_en_q;
    assign gmii_tx_er    = tx_er_q;
    assign s_axis_tready = tready_q;
    assign start_packet  = start_q;
    assign er_underflow  = uf_q;

endmodule

// File: tb/tb_axis_gmii_tx.sv
// Scoreboard bench for axis_gmii_tx: expected GMII bytes are queued as frames are driven
// and compared every tx_en cycle; an unpadded and a padded instance share the stimulus.
module tb_axis_gmii_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_user = 1'b0;
    logic       sel_np = 1'b1;

    logic [7:0] np_txd, p_txd;
    logic       np_en, p_en, np_er, p_er, np_rdy, p_rdy, np_sp, p_sp, np_uf, p_uf;
    logic [7:0] m_txd;
    logic       m_en, m_er, m_tready, m_sp, m_uf;

    always #5 clk = ~clk;

    axis_gmii_tx #(.DATA_W(8), .ENABLE_PADDING(1'b0), .MIN_FRAME_LEN(64), .IFG_CYCLES(12)) dut_np (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid & sel_np), .s_axis_tready(np_rdy),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .gmii_txd(np_txd), .gmii_tx_en(np_en), .gmii_tx_er(np_er),
        .start_packet(np_sp), .er_underflow(np_uf)
    );

    axis_gmii_tx #(.DATA_W(8), .ENABLE_PADDING(1'b1), .MIN_FRAME_LEN(64), .IFG_CYCLES(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid & ~sel_np), .s_axis_tready(p_rdy),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user),
        .gmii_txd(p_txd), .gmii_tx_en(p_en), .gmii_tx_er(p_er),
        .start_packet(p_sp), .er_underflow(p_uf)
    );

    assign m_txd    = sel_np ? np_txd : p_txd;
    assign m_en     = sel_np ? np_en  : p_en;
    assign m_er     = sel_np ? np_er  : p_er;
    assign m_tready = sel_np ? np_rdy : p_rdy;
    assign m_sp     = sel_np ? np_sp  : p_sp;
    assign m_uf     = sel_np ? np_uf  : p_uf;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    // scoreboard entry: {er_underflow, tx_er, txd}
    logic [9:0] exp_q[$];
    logic [9:0] beats[$];   // {tuser, tlast, tdata}
    logic [7:0] pay[$];
    int         frames_exp = 0;
    int         sp_count = 0;
    int         idle_run = 0;
    int         last_gap = 0;
    logic       prev_en = 1'b0;

    always @(negedge clk) begin
        if (m_en) begin
            check("start_pulse", 32'(m_sp), 32'(!prev_en));
            check("gmii_byte", 32'({m_uf, m_er, m_txd}),
                  32'((exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF));
            if (!prev_en) last_gap = idle_run;
            idle_run = 0;
        end else begin
            check("idle_flags", 32'({m_er, m_uf, m_sp}), 32'(0));
            idle_run++;
        end
        if (m_sp) sp_count++;
        prev_en = m_en;
    end

    // Independent CRC model: non-reflected MSB-first register fed reflected input bits.
    function automatic logic [31:0] model_step(input logic [31:0] r, input logic [7:0] d);
        logic [31:0] x;
        logic        fb;
        x = r;
        for (int k = 0; k < 8; k++) begin
            fb = x[31] ^ d[k];
            x  = x << 1;
            if (fb) x = x ^ 32'h04C11DB7;
        end
        return x;
    endfunction

    function automatic logic [31:0] model_fcs(input logic [31:0] r);
        logic [31:0] rev;
        for (int k = 0; k < 32; k++) rev[k] = r[31-k];
        return ~rev;
    endfunction

    task automatic push_preamble();
        for (int i = 0; i < 7; i++) exp_q.push_back({2'b00, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
        frames_exp++;
    endtask

    task automatic make_payload(input int n, input bit user);
        logic [7:0] b;
        pay.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            pay.push_back(b);
            beats.push_back({user && (i == n - 1), i == n - 1, b});
        end
    endtask

    task automatic expect_frame(input bit user, input bit pad, input int uf_at);
        logic [31:0] r;
        logic [31:0] fcs;
        int          n;
        push_preamble();
        r = 32'hFFFFFFFF;
        n = 0;
        for (int i = 0; i < pay.size(); i++) begin
            if (i == uf_at) begin
                exp_q.push_back({2'b11, 8'h00});
                return;
            end
            exp_q.push_back({1'b0, user && (i == pay.size() - 1), pay[i]});
            r = model_step(r, pay[i]);
            n++;
        end
        if (pad) begin
            while (n < 60) begin
                exp_q.push_back({2'b00, 8'h00});
                r = model_step(r, 8'h00);
                n++;
            end
        end
        fcs = model_fcs(r);
        for (int k = 0; k < 4; k++) exp_q.push_back({2'b00, fcs[8*k +: 8]});
    endtask

    task automatic drive(input int drop_at);
        int i = 0;
        int guard = 0;
        bit dropped = 1'b0;
        while (beats.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            {s_user, s_last, s_data} = beats[0];
            if (i == drop_at && !dropped && m_tready) begin
                s_valid = 1'b0;
                dropped = 1'b1;
            end else begin
                s_valid = 1'b1;
                if (m_tready) begin
                    void'(beats.pop_front());
                    i++;
                end
            end
        end
        check("drive_done", 32'(beats.size()), 32'(0));
        beats.delete();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int guard;
        #2;
        check("rst_np", 32'({np_txd, np_en, np_er, np_rdy, np_sp, np_uf}), 32'(0));
        check("rst_p", 32'({p_txd, p_en, p_er, p_rdy, p_sp, p_uf}), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unpadded "123456789": FCS bytes are the well-known CRC-32 0xCBF43926, LSB first.
        sel_np = 1'b1;
        push_preamble();
        for (int i = 0; i < 9; i++) begin
            beats.push_back({1'b0, i == 8, 8'(8'h31 + i)});
            exp_q.push_back({2'b00, 8'(8'h31 + i)});
        end
        exp_q.push_back({2'b00, 8'h26});
        exp_q.push_back({2'b00, 8'h39});
        exp_q.push_back({2'b00, 8'hF4});
        exp_q.push_back({2'b00, 8'hCB});
        drive(-1);
        wait_drain();
        check("gap_after_np", 32'(idle_run >= 12), 32'(1));

        sel_np = 1'b0;
        repeat (2) @(negedge clk);

        // 14-byte payload padded to 60 bytes before FCS.
        make_payload(14, 1'b0);
        expect_frame(1'b0, 1'b1, -1);
        drive(-1);
        wait_drain();

        // Back-to-back 64-byte frames with tvalid never dropping.
        make_payload(60, 1'b0);
        expect_frame(1'b0, 1'b1, -1);
        make_payload(60, 1'b0);
        expect_frame(1'b0, 1'b1, -1);
        drive(-1);
        wait_drain();
        check("b2b_gap", 32'(last_gap), 32'(13));

        // Source starves at payload byte 20.
        make_payload(40, 1'b0);
        expect_frame(1'b0, 1'b1, 20);
        drive(20);
        wait_drain();

        // Bad-frame marker on the last byte, padding and FCS still follow.
        make_payload(30, 1'b1);
        expect_frame(1'b1, 1'b1, -1);
        drive(-1);
        wait_drain();

        // Reset in the middle of FCS byte 2.
        make_payload(20, 1'b0);
        expect_frame(1'b0, 1'b1, -1);
        drive(-1);
        guard = 0;
        while (exp_q.size() != 1 && guard < 1000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("rst_reach_fcs2", 32'(exp_q.size()), 32'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_fcs", 32'({m_en, m_er, m_txd, m_tready, m_uf}), 32'(0));
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame after reset release must carry a fresh CRC.
        make_payload(25, 1'b0);
        expect_frame(1'b0, 1'b1, -1);
        drive(-1);
        wait_drain();

        check("start_count", 32'(sp_count), 32'(frames_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
